// File: rtl/system_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : system_sysid_checker
// Purpose  : Reads system ID and build timestamp over Avalon-MM, compares both
// Revision : 1.0
// ============================================================================
module system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1449291988,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] C_WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_wait_cnt;
  logic        w_in_read;
  logic        w_accept;
  logic        w_expire;

  assign w_in_read = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign w_accept  = w_in_read && !waitrequest;
  // Abort on the edge that would complete the TIMEOUT-th stalled cycle.
  assign w_expire  = w_in_read && waitrequest && (r_wait_cnt == C_WAIT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    read        = 1'b0;
    address     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_RD_ID;
      end
      S_RD_ID: begin
        read = 1'b1;
        if (w_expire)      w_state_nxt = S_DONE;
        else if (w_accept) w_state_nxt = S_RD_TS;
      end
      S_RD_TS: begin
        read    = 1'b1;
        address = 1'b1;
        if (w_expire || w_accept) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            r_wait_cnt <= '0;
    else if (w_in_read && waitrequest && !w_expire) r_wait_cnt <= r_wait_cnt + 16'd1;
    else                                     r_wait_cnt <= '0;
  end

  // Results are registered on the edge entering DONE so they are valid with done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value    <= '0;
      ts_value    <= '0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
    end else if (w_expire) begin
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b1;
    end else if (w_accept) begin
      if (r_state == S_RD_ID) begin
        id_value <= readdata;
      end else begin
        ts_value    <= readdata;
        id_ok       <= (id_value == EXPECTED_ID);
        ts_ok       <= (readdata == EXPECTED_TS);
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
